// File: rtl/receive_pkg.sv
// Shared types and line-level constants for the UART receiver.
package receive_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT
   } rx_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/receive_sync2.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] stage_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stage
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stage_reg[gi] <= RST_VAL;
            end else begin
               stage_reg[gi] <= (gi == 0) ? d : stage_reg[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign q = stage_reg[1];

endmodule

// File: rtl/receive.sv
// UART 8N1 receiver: oversamples din, emits each good byte with a one-cycle din_vld.
// Optional frame_err pulse port is enabled by defining RECEIVE_FRAME_ERR_EN.
module receive
   import receive_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   output logic                 din_vld,
   output logic [DATA_BITS-1:0] din_data
`ifdef RECEIVE_FRAME_ERR_EN
   ,
   output logic                 frame_err
`endif
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   generate
      if (DIV < 4) begin : g_bad_div
         $error("receive: CLK_FREQ/BAUD must be at least 4");
      end
   endgenerate

   logic s2;

   rx_state_t              state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [2:0]             bitn_reg, bitn_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   din_vld_reg, din_vld_next;
   logic [DATA_BITS-1:0]   din_data_reg, din_data_next;
`ifdef RECEIVE_FRAME_ERR_EN
   logic                   frame_err_reg, frame_err_next;
`endif

   sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s2)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bitn_reg      <= '0;
         shift_reg     <= '0;
         din_vld_reg   <= 1'b0;
         din_data_reg  <= '0;
`ifdef RECEIVE_FRAME_ERR_EN
         frame_err_reg <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bitn_reg      <= bitn_next;
         shift_reg     <= shift_next;
         din_vld_reg   <= din_vld_next;
         din_data_reg  <= din_data_next;
`ifdef RECEIVE_FRAME_ERR_EN
         frame_err_reg <= frame_err_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bitn_next      = bitn_reg;
      shift_next     = shift_reg;
      din_vld_next   = 1'b0;
      din_data_next  = din_data_reg;
`ifdef RECEIVE_FRAME_ERR_EN
      frame_err_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (s2 == START_LEVEL) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         // Re-check the line at mid start bit so short lows are rejected as glitches.
         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next  = '0;
               bitn_next = '0;
               state_next = (s2 == START_LEVEL) ? DATA : IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               shift_next = {s2, shift_reg[DATA_BITS-1:1]};
               cnt_next   = '0;
               bitn_next  = bitn_reg + 1'b1;
               if (bitn_reg == LAST_BIT) begin
                  state_next = STOP;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         // Leaving at mid stop bit leaves half a bit of slack for a back-to-back start.
         STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next = '0;
               if (s2 == STOP_LEVEL) begin
                  din_data_next = shift_reg;
                  din_vld_next  = 1'b1;
                  state_next    = IDLE;
               end else begin
`ifdef RECEIVE_FRAME_ERR_EN
                  frame_err_next = 1'b1;
`endif
                  state_next = WAIT;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT: begin
            if (s2 == IDLE_LEVEL) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign din_vld  = din_vld_reg;
   assign din_data = din_data_reg;
`ifdef RECEIVE_FRAME_ERR_EN
   assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_receive.sv
// Directed bench for receive at DIV = 16: table of frames plus glitch, back-to-back and reset corners.
module tb_receive;
   import receive_pkg::*;

   localparam int DIV = 16;
   localparam int LAT = 2 + DIV / 2 + 9 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b1;
   logic       din_vld;
   logic [7:0] din_data;
`ifdef RECEIVE_FRAME_ERR_EN
   logic       frame_err;
   int         fe_cnt = 0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         vld_cyc_q[$];
   logic [7:0] vld_data_q[$];

   receive #(.CLK_FREQ(16), .BAUD(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .din_data (din_data)
`ifdef RECEIVE_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (din_vld === 1'b1) begin
         vld_cyc_q.push_back(cyc);
         vld_data_q.push_back(din_data);
      end
`ifdef RECEIVE_FRAME_ERR_EN
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
`endif
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold din at v for n clock cycles; always returns 1 ns after a rising edge.
   task automatic drive_bit(input logic v, input int n);
      din = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0, DIV);
      for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
      drive_bit(stop, DIV);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_pulses;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n0;
      int e0;
      int e1;
`ifdef RECEIVE_FRAME_ERR_EN
      int f0;
`endif
      vecs[0] = '{8'h30, 1'b1, 1, 8'h30};
      vecs[1] = '{8'hA5, 1'b0, 0, 8'h30};
      vecs[2] = '{8'h00, 1'b1, 1, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF};
      vecs[4] = '{8'h5A, 1'b0, 0, 8'hFF};
      vecs[5] = '{8'h81, 1'b1, 1, 8'h81};

      // Reset
      rst = 1'b0;
      din = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_vld", din_vld, 1'b0);
      check("reset_data", din_data, 8'h00);
      rst = 1'b1;
      drive_bit(1'b1, 200);
      check("idle_no_pulse", vld_cyc_q.size(), 0);
      check("idle_state", dut.state_reg, IDLE);
      $display("reset: vld=%0b data=%02h pulses=%0d", din_vld, din_data, vld_cyc_q.size());

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         n0 = vld_cyc_q.size();
         e0 = cyc + 1;
`ifdef RECEIVE_FRAME_ERR_EN
         f0 = fe_cnt;
`endif
         send_frame(vecs[v].data, vecs[v].stop);
         if (!vecs[v].stop) begin
            drive_bit(1'b0, 50);
            check($sformatf("v%0d_wait_state", v), dut.state_reg, WAIT);
         end
         drive_bit(1'b1, 2 * DIV);
         check($sformatf("v%0d_pulses", v), vld_cyc_q.size() - n0, vecs[v].exp_pulses);
         if (vecs[v].exp_pulses > 0 && vld_cyc_q.size() > n0) begin
            check($sformatf("v%0d_latency", v), vld_cyc_q[n0] - e0, LAT);
            check($sformatf("v%0d_pulse_data", v), vld_data_q[n0], vecs[v].exp_data);
         end
         check($sformatf("v%0d_din_data", v), din_data, vecs[v].exp_data);
         check($sformatf("v%0d_idle", v), dut.state_reg, IDLE);
`ifdef RECEIVE_FRAME_ERR_EN
         check($sformatf("v%0d_frame_err", v), fe_cnt - f0, vecs[v].stop ? 0 : 1);
`endif
         $display("frame %02h stop=%0b pulses=%0d din_data=%02h", vecs[v].data, vecs[v].stop,
                  vld_cyc_q.size() - n0, din_data);
      end

      // Glitch: 4 low cycles must not start a frame
      n0 = vld_cyc_q.size();
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 2);
      check("glitch_in_start", dut.state_reg, START);
      drive_bit(1'b1, DIV / 2 + 1);
      check("glitch_idle", dut.state_reg, IDLE);
      drive_bit(1'b1, 10 * DIV);
      check("glitch_no_pulse", vld_cyc_q.size() - n0, 0);
      $display("glitch: pulses=%0d din_data=%02h", vld_cyc_q.size() - n0, din_data);

      // Back-to-back frames with no idle gap
      n0 = vld_cyc_q.size();
      e0 = cyc + 1;
      send_frame(8'h55, 1'b1);
      send_frame(8'hA3, 1'b1);
      drive_bit(1'b1, 2 * DIV);
      check("b2b_pulses", vld_cyc_q.size() - n0, 2);
      if (vld_cyc_q.size() - n0 == 2) begin
         check("b2b_latency", vld_cyc_q[n0] - e0, LAT);
         check("b2b_spacing", vld_cyc_q[n0+1] - vld_cyc_q[n0], 10 * DIV);
         check("b2b_data0", vld_data_q[n0], 8'h55);
         check("b2b_data1", vld_data_q[n0+1], 8'hA3);
      end
      $display("back-to-back: pulses=%0d din_data=%02h", vld_cyc_q.size() - n0, din_data);

      // Reset during data bit 3 of 8'hFF
      n0 = vld_cyc_q.size();
      drive_bit(1'b0, DIV);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, DIV);
      drive_bit(1'b1, DIV / 2);
      rst = 1'b0;
      #1;
      check("midrst_data_async", din_data, 8'h00);
      drive_bit(1'b1, 3);
      rst = 1'b1;
      drive_bit(1'b1, 12 * DIV);
      check("midrst_no_pulse", vld_cyc_q.size() - n0, 0);
      check("midrst_data", din_data, 8'h00);
      $display("reset mid-frame: pulses=%0d din_data=%02h", vld_cyc_q.size() - n0, din_data);

      n0 = vld_cyc_q.size();
      e0 = cyc + 1;
      send_frame(8'h0F, 1'b1);
      drive_bit(1'b1, 2 * DIV);
      check("after_rst_pulses", vld_cyc_q.size() - n0, 1);
      if (vld_cyc_q.size() > n0) begin
         check("after_rst_latency", vld_cyc_q[n0] - e0, LAT);
         check("after_rst_data", vld_data_q[n0], 8'h0F);
      end
      e1 = vld_cyc_q.size() - n0;
      $display("frame 0f after reset: pulses=%0d din_data=%02h", e1, din_data);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
